// File: rtl/montre_de1_cpu_jtag_pkg.sv
// rtl/montre_de1_cpu_jtag_pkg.sv - shared defaults and IR encodings for the JTAG debug command path
package montre_de1_cpu_jtag_pkg;

  localparam int SR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } jtag_ir_e;

endpackage

// File: rtl/montre_de1_cpu_jtag_cmd_fifo.sv
// rtl/montre_de1_cpu_jtag_cmd_fifo.sv - show-ahead command FIFO with wrap-bit pointers
module montre_de1_cpu_jtag_cmd_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         overflow_evt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same edge, so a push into a full FIFO still lands.
  assign do_pop       = pop & ~empty;
  assign do_push      = push & (~full | do_pop);
  assign overflow_evt = push & full & ~do_pop;

  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/montre_de1_cpu_jtag_cmd_decoder.sv
// rtl/montre_de1_cpu_jtag_cmd_decoder.sv - TCK-strobe synchronizer, command queue and action pulse decoder
module montre_de1_cpu_jtag_cmd_decoder
  import montre_de1_cpu_jtag_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ACT_BIT     = SR_W - 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [SR_W-1:0]      sr,
  input  logic                 cmd_ready,
  input  logic                 clr_overflow,
  output logic                 cmd_valid,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [SR_W-1:0]      jdo,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 overflow,
  output logic [15:0]          cmd_count
);

  localparam int NCH = 2**IR_W;
  localparam int CW  = IR_W + SR_W;

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_hist;
  logic                   udr_hist;
  logic                   uir_pulse;
  logic                   udr_pulse;
  logic [IR_W-1:0]        ir_reg;
  logic [CW-1:0]          head_data;
  logic [SR_W-1:0]        head_sr;
  logic                   fifo_empty;
  logic                   overflow_evt;
  logic                   cmd_pop;
  logic [NCH-1:0]         ch_onehot;

  // The history flop makes each strobe one pulse per rising edge, however long TCK holds it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_hist <= 1'b0;
      udr_hist <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_hist <= uir_sync[SYNC_STAGES-1];
      udr_hist <= udr_sync[SYNC_STAGES-1];
    end
  end

  assign uir_pulse = uir_sync[SYNC_STAGES-1] & ~uir_hist;
  assign udr_pulse = udr_sync[SYNC_STAGES-1] & ~udr_hist;

  always_ff @(posedge clk) begin
    if (!reset_n)       ir_reg <= '0;
    else if (uir_pulse) ir_reg <= ir_in;
  end

  // ir_reg is sampled before its update, so a coincident IR strobe applies to the next command.
  montre_de1_cpu_jtag_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (udr_pulse),
    .push_data    ({ir_reg, sr}),
    .pop          (cmd_pop),
    .head_data    (head_data),
    .empty        (fifo_empty),
    .overflow_evt (overflow_evt)
  );

  assign cmd_valid = ~fifo_empty;
  assign cmd_ir    = head_data[CW-1:SR_W];
  assign head_sr   = head_data[SR_W-1:0];
  assign cmd_pop   = cmd_valid & cmd_ready;

  always_comb begin
    ch_onehot         = '0;
    ch_onehot[cmd_ir] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      overflow       <= 1'b0;
      cmd_count      <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (cmd_pop) begin
        jdo       <= head_sr;
        cmd_count <= cmd_count + 16'd1;
        if (head_sr[ACT_BIT]) take_action    <= ch_onehot;
        else                  take_no_action <= ch_onehot;
      end
      if (overflow_evt)      overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_montre_de1_cpu_jtag_cmd_decoder.sv
// tb/tb_montre_de1_cpu_jtag_cmd_decoder.sv - table-driven scoreboard bench for the JTAG command decoder
module tb_montre_de1_cpu_jtag_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_uir;
  logic        vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready;
  logic        clr_overflow;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        overflow;
  logic [15:0] cmd_count;

  always #5 clk = ~clk;

  montre_de1_cpu_jtag_cmd_decoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .clr_overflow   (clr_overflow),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .overflow       (overflow),
    .cmd_count      (cmd_count)
  );

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] sr;
    logic [3:0]  act;
    logic [3:0]  nact;
  } vec_t;

  vec_t        vecs [8];
  vec_t        q [$];
  vec_t        pend;
  int          n_vec = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          pop_pend = 1'b0;
  logic [37:0] last_jdo = '0;
  logic [15:0] exp_count = '0;
  logic [15:0] n_acc = '0;
  logic [1:0]  cur_ir = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] ir, input logic [37:0] s);
    vec_t v;
    v.ir   = ir;
    v.sr   = s;
    v.act  = s[35] ? (4'b0001 << ir) : 4'b0000;
    v.nact = s[35] ? 4'b0000 : (4'b0001 << ir);
    return v;
  endfunction

  // Monitor: checks the cycle after each pop and idles between pops.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pop_pend) begin
        check("jdo", 64'(jdo), 64'(pend.sr));
        check("take_action", 64'(take_action), 64'(pend.act));
        check("take_no_action", 64'(take_no_action), 64'(pend.nact));
        check("cmd_count", 64'(cmd_count), 64'(exp_count));
        last_jdo = pend.sr;
      end else begin
        check("idle_take_action", 64'(take_action), 64'd0);
        check("idle_take_no_action", 64'(take_no_action), 64'd0);
        check("jdo_hold", 64'(jdo), 64'(last_jdo));
      end
      pop_pend = 1'b0;
      if (cmd_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_valid: cmd_valid=1 expected 0 (no command outstanding)");
        end else begin
          check("cmd_ir", 64'(cmd_ir), 64'(q[0].ir));
          if (cmd_ready) begin
            pend      = q.pop_front();
            pop_pend  = 1'b1;
            exp_count = exp_count + 16'd1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    tick(n);
    reset_n = 1'b1;
    q.delete();
    pop_pend  = 1'b0;
    last_jdo  = '0;
    exp_count = '0;
    n_acc     = '0;
    cur_ir    = '0;
  endtask

  task automatic send_uir(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    tick(3);
    cur_ir = ir;
  endtask

  task automatic send_udr(input vec_t v, input bit accept);
    sr = v.sr;
    if (accept) begin
      q.push_back(v);
      n_acc = n_acc + 16'd1;
    end
    vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    tick(3);
  endtask

  task automatic drain();
    int k;
    cmd_ready = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      tick(1);
      k++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d commands still queued, expected 0", q.size());
    end
    tick(2);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{2'd2, 38'h8_1234_5678, 4'b0100, 4'b0000};
    vecs[1] = '{2'd1, 38'h7_FFFF_FFFF, 4'b0000, 4'b0010};
    vecs[2] = '{2'd0, 38'hF_0F0F_0F0F, 4'b0001, 4'b0000};
    vecs[3] = '{2'd3, 38'h1_2345_6789, 4'b0000, 4'b1000};
    vecs[4] = '{2'd3, 38'hC_0000_0001, 4'b1000, 4'b0000};
    vecs[5] = '{2'd0, {2'b11, 36'h0_0000_0055}, 4'b0000, 4'b0001};
    vecs[6] = '{2'd2, {2'b01, 36'h8_0000_0000}, 4'b0100, 4'b0000};
    vecs[7] = '{2'd1, 38'h0, 4'b0000, 4'b0010};

    vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; clr_overflow = 1'b0;
    do_reset(3);
    @(negedge clk);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_cmd_count", 64'(cmd_count), 64'd0);
    check("rst_take_action", 64'(take_action), 64'd0);
    check("rst_take_no_action", 64'(take_no_action), 64'd0);
    mon_en = 1'b1;
    tick(1);

    // Latency from the first edge that samples vs_udr high.
    send_uir(vecs[0].ir);
    sr = vecs[0].sr;
    q.push_back(vecs[0]);
    n_acc = n_acc + 16'd1;
    vs_udr = 1'b1;
    @(posedge clk);
    @(negedge clk); check("lat_edge1", 64'(cmd_valid), 64'd0);
    @(negedge clk); check("lat_edge2", 64'(cmd_valid), 64'd0);
    @(negedge clk); check("lat_edge3", 64'(cmd_valid), 64'd1);
    @(posedge clk); #1;
    tick(1);
    vs_udr = 1'b0;
    tick(3);
    drain();

    for (int i = 1; i < 8; i++) begin
      send_uir(vecs[i].ir);
      send_udr(vecs[i], 1'b1);
      drain();
    end

    // Five strobes into a depth-4 queue with no consumer.
    cmd_ready = 1'b0;
    send_uir(2'd1);
    for (int k = 0; k < 5; k++) begin
      send_udr(mk(cur_ir, vecs[k].sr), k < 4);
      if (k == 3) check("ovf_before_drop", 64'(overflow), 64'd0);
    end
    @(negedge clk);
    check("ovf_set", 64'(overflow), 64'd1);
    tick(1);
    drain();
    @(negedge clk);
    check("ovf_count", 64'(cmd_count), 64'(n_acc));
    check("ovf_jdo_4th", 64'(jdo), 64'(vecs[3].sr));
    check("ovf_sticky", 64'(overflow), 64'd1);
    tick(1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 64'(overflow), 64'd0);
    tick(1);

    // Full queue: push and pop land on the same edge.
    cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_udr(mk(cur_ir, vecs[k+4].sr), 1'b1);
    v = mk(cur_ir, vecs[2].sr);
    sr = v.sr;
    q.push_back(v);
    n_acc = n_acc + 16'd1;
    vs_udr = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    tick(1);
    vs_udr = 1'b0;
    tick(3);
    drain();
    @(negedge clk);
    check("full_pushpop_ovf", 64'(overflow), 64'd0);
    check("full_pushpop_count", 64'(cmd_count), 64'(n_acc));
    tick(1);

    // Coincident IR and DR strobes: the command carries the previous IR.
    v = mk(cur_ir, vecs[0].sr);
    q.push_back(v);
    n_acc = n_acc + 16'd1;
    ir_in = 2'd3;
    sr = v.sr;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick(3);
    cur_ir = 2'd3;
    drain();
    send_udr(mk(cur_ir, vecs[1].sr), 1'b1);
    drain();

    // A long DR level is a single command.
    cmd_ready = 1'b0;
    v = mk(cur_ir, vecs[4].sr);
    sr = v.sr;
    q.push_back(v);
    n_acc = n_acc + 16'd1;
    vs_udr = 1'b1;
    tick(50);
    vs_udr = 1'b0;
    tick(3);
    drain();
    @(negedge clk);
    check("held_one_push", 64'(cmd_valid), 64'd0);
    check("held_count", 64'(cmd_count), 64'(n_acc));
    tick(1);

    // Reset with commands queued and overflow set.
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_udr(mk(cur_ir, vecs[k].sr), k < 4);
    @(negedge clk);
    check("pre_reset_valid", 64'(cmd_valid), 64'd1);
    check("pre_reset_ovf", 64'(overflow), 64'd1);
    tick(1);
    do_reset(1);
    @(negedge clk);
    check("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("midrst_jdo", 64'(jdo), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    check("midrst_cmd_count", 64'(cmd_count), 64'd0);
    mon_en = 1'b1;
    tick(1);

    // DR level held through reset release gives one command with the reset IR.
    vs_udr = 1'b1;
    sr = vecs[2].sr;
    tick(2);
    do_reset(2);
    q.push_back(mk(2'd0, vecs[2].sr));
    n_acc = n_acc + 16'd1;
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk); check("rel_edge1", 64'(cmd_valid), 64'd0);
    @(negedge clk); check("rel_edge2", 64'(cmd_valid), 64'd0);
    @(negedge clk); check("rel_edge3", 64'(cmd_valid), 64'd1);
    @(posedge clk); #1;
    vs_udr = 1'b0;
    tick(3);
    drain();
    @(negedge clk);
    check("rel_count", 64'(cmd_count), 64'(n_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/montre_de1_cpu_jtag_cmd_decoder.md
MONTRE_DE1_CPU_JTAG_CMD_DECODER -- requirements
Module: montre_de1_cpu_jtag_cmd_decoder

Interface
REQ-001 Parameter SR_W, default 38: JTAG data shift register width; SHALL be at least 8.
REQ-002 Parameter IR_W, default 2: instruction width; NCH = 2**IR_W action channels.
REQ-003 Parameter DEPTH, default 4: command FIFO depth; SHALL be a power of two, at least 2.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth for TCK-domain strobes; SHALL be at least 2.
REQ-005 Parameter ACT_BIT, default SR_W-3: index of the sr bit that selects action versus no-action.
REQ-006 Port clk, input, 1: system clock; the only clock in the block.
REQ-007 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-008 Port vs_uir, input, 1: update-IR level from the TCK domain; asynchronous to clk.
REQ-009 Port vs_udr, input, 1: update-DR level from the TCK domain; asynchronous to clk.
REQ-010 Port ir_in, input, IR_W: instruction; stable while vs_uir is high.
REQ-011 Port sr, input, SR_W: shift register contents; stable while vs_udr is high.
REQ-012 Port cmd_ready, input, 1: consumer accepts the head command.
REQ-013 Port clr_overflow, input, 1: clears overflow.
REQ-014 Port cmd_valid, output, 1: FIFO is non-empty.
REQ-015 Port cmd_ir, output, IR_W: IR of the head command.
REQ-016 Port jdo, output, SR_W: sr of the last popped command.
REQ-017 Port take_action, output, NCH: one-hot, single-cycle pulse.
REQ-018 Port take_no_action, output, NCH: one-hot, single-cycle pulse.
REQ-019 Port overflow, output, 1: sticky flag, set when a command is dropped.
REQ-020 Port cmd_count, output, 16: popped-command counter.

Function
REQ-021 vs_uir and vs_udr SHALL each pass through a SYNC_STAGES flop chain, followed by one history flop.
REQ-022 Edge detect SHALL be last stage AND NOT history, giving one pulse per input rising edge regardless of input high time.
REQ-023 On a uir pulse, the block SHALL load ir_reg from ir_in.
REQ-024 On a udr pulse, the block SHALL push {ir_reg, sr} into the FIFO.
REQ-025 On simultaneous uir and udr pulses, the push SHALL use the old ir_reg, and ir_reg SHALL update in the same cycle.
REQ-026 Latency: cmd_valid SHALL rise SYNC_STAGES+1 clk edges after the first edge that samples vs_udr high, when the FIFO was empty.
REQ-027 cmd_valid and cmd_ir SHALL be driven directly from FIFO state with no extra register; show-ahead.
REQ-028 A pop occurs at an edge where cmd_valid and cmd_ready are both high.
REQ-029 On a pop, the next cycle SHALL present jdo equal to the popped sr.
REQ-030 In that same next cycle, take_action[cmd_ir] SHALL be 1 if sr[ACT_BIT] is 1; otherwise take_no_action[cmd_ir] SHALL be 1.
REQ-031 take_action and take_no_action SHALL be all-zero whenever no pop occurred at the previous edge.
REQ-032 jdo SHALL hold its value between pops.
REQ-033 A push when full and without a simultaneous pop SHALL drop the command and set overflow.
REQ-034 A simultaneous push and pop when full SHALL both succeed with no overflow.
REQ-035 A push and pop in the same cycle when empty SHALL push only; cmd_valid was low.
REQ-036 clr_overflow SHALL clear overflow; if an overflow event occurs in the same cycle, set wins.
REQ-037 cmd_count SHALL increment by 1 per pop and wrap from 16'hFFFF to 0.

Reset
REQ-038 While reset_n is low at an edge, the block SHALL clear:
- sync chains and history flops
- ir_reg
- FIFO pointers and occupancy
- jdo
- take_action and take_no_action
- overflow
- cmd_count
REQ-039 Reset mid-operation SHALL discard queued commands, with cmd_valid low in the first cycle after the reset edge.
REQ-040 A vs_udr level held high through reset release SHALL generate one push SYNC_STAGES+1 edges after release; the history flop starts at 0.

Structure
REQ-041 The shared package montre_de1_cpu_jtag_pkg SHALL hold the default parameters and IR encodings:
- IR_OCIMEM = 0
- IR_TRACEMEM = 1
- IR_BREAK = 2
- IR_TRACECTRL = 3
REQ-042 The FIFO SHALL be a sub-module montre_de1_cpu_jtag_cmd_fifo, parametrised by width and depth.
- Pointers SHALL be log2(DEPTH)+1 bits, with a wrap bit for full/empty.

Verification
REQ-043 Defaults; ir_in=2 with a vs_uir pulse; then sr bit35=1 with a vs_udr pulse; cmd_ready=1 -> cmd_valid high 3 edges after vs_udr sampled high; next cycle take_action=4'b0100 for one cycle, jdo=sr.
REQ-044 Same sequence with ir_in=1 and sr bit35=0 -> take_no_action=4'b0010; take_action stays 0.
REQ-045 cmd_ready=0; 5 udr pulses -> 4 queued; overflow=1; after draining, cmd_count=4 and jdo equals the 4th sr.
REQ-046 FIFO full, cmd_ready=1, new udr pulse -> push and pop in the same cycle; overflow stays 0.
REQ-047 vs_udr held high for 50 cycles -> exactly one push.
REQ-048 Two commands queued, reset_n=0 for one edge -> cmd_valid=0, jdo=0, overflow=0, cmd_count=0.
